// File: rtl/cache_mem_arbiter.sv
// Round-robin arbiter sharing one line-burst main-memory port between the I-cache (0) and D-cache (1).
// Optional stall watchdog is compiled in when CACHE_ARB_TIMEOUT_EN is defined.
module cache_mem_arbiter #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 8,
  parameter int BURST_LEN = 4,
  parameter int TIMEOUT   = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              rd_mem_0,
  input  logic              wr_mem_0,
  input  logic [ADDR_W-1:0] addr_mem_0,
  input  logic [DATA_W-1:0] wdata_0,
  output logic [DATA_W-1:0] rdata_0,
  output logic              ready_mem_0,
  input  logic              rd_mem_1,
  input  logic              wr_mem_1,
  input  logic [ADDR_W-1:0] addr_mem_1,
  input  logic [DATA_W-1:0] wdata_1,
  output logic [DATA_W-1:0] rdata_1,
  output logic              ready_mem_1,
  output logic [ADDR_W-1:0] addr_mem,
  output logic              rd_mem,
  output logic              wr_mem,
  output logic [DATA_W-1:0] wdata_mem,
  input  logic [DATA_W-1:0] rdata_mem,
  input  logic              ready_mem,
  output logic [1:0]        gnt,
  output logic              busy,
  output logic              err_timeout
);

  localparam int CNT_W = $clog2(BURST_LEN) + 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

  if (BURST_LEN < 2 || TIMEOUT < 2) begin : g_bad_params
    $error("cache_mem_arbiter: BURST_LEN and TIMEOUT must both be at least 2");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       gnt_q, gnt_d;
  logic             last_q, last_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;

  logic req_0, req_1, req_granted, final_beat, pick_1, timeout_hit;

  assign req_0       = rd_mem_0 | wr_mem_0;
  assign req_1       = rd_mem_1 | wr_mem_1;
  assign req_granted = (gnt_q[0] & req_0) | (gnt_q[1] & req_1);
  assign final_beat  = ready_mem && (beat_cnt_q == LAST_BEAT);
  // last_q holds the index of the most recent owner, so a tie goes to the other one.
  assign pick_1      = (req_0 && req_1) ? ~last_q : req_1;

  // NOTE: every variable gets a default before the case so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    last_d     = last_q;
    beat_cnt_d = beat_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (req_0 || req_1) begin
          gnt_d      = pick_1 ? 2'b10 : 2'b01;
          last_d     = pick_1;
          beat_cnt_d = '0;
          state_d    = BUSY;
        end
      end
      BUSY: begin
        if (ready_mem && (beat_cnt_q != '1)) begin
          beat_cnt_d = beat_cnt_q + CNT_W'(1);
        end
        if (final_beat || !req_granted || timeout_hit) begin
          gnt_d   = 2'b00;
          state_d = DONE;
        end
      end
      DONE: begin
        gnt_d      = 2'b00;
        beat_cnt_d = '0;
        state_d    = IDLE;
      end
      default: begin
        gnt_d      = 2'b00;
        beat_cnt_d = '0;
        state_d    = IDLE;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      gnt_q      <= 2'b00;
      last_q     <= 1'b1;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      last_q     <= last_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

`ifdef CACHE_ARB_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT) + 1;

  logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
  logic            err_q;

  // Counter restarts outside BUSY (covers a fresh grant) and on every beat.
  assign timeout_hit = (state_q == BUSY) && !ready_mem && (wd_cnt_q == WD_W'(TIMEOUT - 1));

  always_comb begin
    wd_cnt_d = '0;
    if ((state_q == BUSY) && !ready_mem && !timeout_hit) begin
      wd_cnt_d = wd_cnt_q + WD_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wd_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
      err_q    <= timeout_hit;
    end
  end

  assign err_timeout = err_q;
`else
  assign timeout_hit = 1'b0;
  assign err_timeout = 1'b0;
`endif

  // Memory side follows the registered grant; write wins when a requester raises both.
  always_comb begin
    addr_mem    = '0;
    rd_mem      = 1'b0;
    wr_mem      = 1'b0;
    wdata_mem   = '0;
    rdata_0     = '0;
    rdata_1     = '0;
    ready_mem_0 = 1'b0;
    ready_mem_1 = 1'b0;
    if (gnt_q[0]) begin
      addr_mem    = addr_mem_0;
      wr_mem      = wr_mem_0;
      rd_mem      = rd_mem_0 & ~wr_mem_0;
      wdata_mem   = wdata_0;
      rdata_0     = rdata_mem;
      ready_mem_0 = ready_mem;
    end else if (gnt_q[1]) begin
      addr_mem    = addr_mem_1;
      wr_mem      = wr_mem_1;
      rd_mem      = rd_mem_1 & ~wr_mem_1;
      wdata_mem   = wdata_1;
      rdata_1     = rdata_mem;
      ready_mem_1 = ready_mem;
    end
  end

  assign gnt  = gnt_q;
  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Self-checking bench for cache_mem_arbiter: directed scenarios plus a randomized run
// against a transaction-level model of ownership, beats and the post-burst gap.
module tb_cache_mem_arbiter;

  localparam int ADDR_W    = 16;
  localparam int DATA_W    = 8;
  localparam int BURST_LEN = 4;
  localparam int TIMEOUT   = 64;

  logic              clock = 1'b0;
  logic              reset;
  logic              rd_mem_0, wr_mem_0, rd_mem_1, wr_mem_1;
  logic [ADDR_W-1:0] addr_mem_0, addr_mem_1, addr_mem;
  logic [DATA_W-1:0] wdata_0, wdata_1, rdata_0, rdata_1, wdata_mem, rdata_mem;
  logic              ready_mem_0, ready_mem_1, rd_mem, wr_mem, ready_mem;
  logic [1:0]        gnt;
  logic              busy, err_timeout;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clock = ~clock;

  cache_mem_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_LEN(BURST_LEN), .TIMEOUT(TIMEOUT)
  ) dut (
    .clock(clock), .reset(reset),
    .rd_mem_0(rd_mem_0), .wr_mem_0(wr_mem_0), .addr_mem_0(addr_mem_0), .wdata_0(wdata_0),
    .rdata_0(rdata_0), .ready_mem_0(ready_mem_0),
    .rd_mem_1(rd_mem_1), .wr_mem_1(wr_mem_1), .addr_mem_1(addr_mem_1), .wdata_1(wdata_1),
    .rdata_1(rdata_1), .ready_mem_1(ready_mem_1),
    .addr_mem(addr_mem), .rd_mem(rd_mem), .wr_mem(wr_mem), .wdata_mem(wdata_mem),
    .rdata_mem(rdata_mem), .ready_mem(ready_mem),
    .gnt(gnt), .busy(busy), .err_timeout(err_timeout)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    rd_mem_0 = 1'b0; wr_mem_0 = 1'b0; addr_mem_0 = '0; wdata_0 = '0;
    rd_mem_1 = 1'b0; wr_mem_1 = 1'b0; addr_mem_1 = '0; wdata_1 = '0;
    ready_mem = 1'b0; rdata_mem = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b1;
    rd_mem_0 = 1'b1; wr_mem_1 = 1'b1; addr_mem_0 = 16'h1234; addr_mem_1 = 16'h4321;
    wdata_1 = 8'h77; ready_mem = 1'b1; rdata_mem = 8'h5A;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++;
      if ({gnt, busy, rd_mem, wr_mem, err_timeout} !== 6'b0)
        $display("FAIL reset_ctrl[%0d]: gnt=%b busy=%b rd=%b wr=%b err=%b, want all 0",
                 i, gnt, busy, rd_mem, wr_mem, err_timeout);
      else n_pass++;
      n_checks++;
      if ({addr_mem, wdata_mem, rdata_0, rdata_1, ready_mem_0, ready_mem_1} !== '0)
        $display("FAIL reset_data[%0d]: addr=%h wdata=%h rdata0=%h rdata1=%h rdy0=%b rdy1=%b, want 0",
                 i, addr_mem, wdata_mem, rdata_0, rdata_1, ready_mem_0, ready_mem_1);
      else n_pass++;
    end
    reset = 1'b0;
    clear_inputs();
    tick();
  endtask

  task automatic test_single_read();
    logic [7:0] beats [4];
    beats = '{8'h11, 8'h22, 8'h33, 8'h44};
    do_reset();
    rd_mem_0 = 1'b1; addr_mem_0 = 16'h40B4;
    tick();
    n_checks++;
    if ({gnt, rd_mem, wr_mem, busy, addr_mem} !== {2'b01, 1'b1, 1'b0, 1'b1, 16'h40B4})
      $display("FAIL single_grant: gnt=%b rd=%b wr=%b busy=%b addr=%h, want 01 1 0 1 40b4",
               gnt, rd_mem, wr_mem, busy, addr_mem);
    else n_pass++;
    for (int i = 0; i < BURST_LEN; i++) begin
      ready_mem = 1'b1; rdata_mem = beats[i];
      #1;
      n_checks++;
      if ({gnt, ready_mem_0, rdata_0, ready_mem_1, rdata_1} !== {2'b01, 1'b1, beats[i], 1'b0, 8'h00})
        $display("FAIL single_beat%0d: gnt=%b rdy0=%b rdata0=%h rdy1=%b rdata1=%h, want 01 1 %h 0 00",
                 i, gnt, ready_mem_0, rdata_0, ready_mem_1, rdata_1, beats[i]);
      else n_pass++;
      tick();
    end
    ready_mem = 1'b0; rd_mem_0 = 1'b0;
    n_checks++;
    if ({gnt, busy, rd_mem} !== {2'b00, 1'b1, 1'b0})
      $display("FAIL single_done: gnt=%b busy=%b rd=%b, want 00 1 0", gnt, busy, rd_mem);
    else n_pass++;
    tick();
    n_checks++;
    if ({gnt, busy} !== 3'b000)
      $display("FAIL single_idle: gnt=%b busy=%b, want 00 0", gnt, busy);
    else n_pass++;
  endtask

  task automatic test_round_robin();
    int owner;
    do_reset();
    rd_mem_0 = 1'b1; addr_mem_0 = 16'h1000;
    wr_mem_1 = 1'b1; addr_mem_1 = 16'h2000; wdata_1 = 8'hC3;
    tick();
    for (int g = 0; g < 4; g++) begin
      owner = g % 2;
      n_checks++;
      if (owner == 0 && {gnt, rd_mem, wr_mem, addr_mem} !== {2'b01, 1'b1, 1'b0, 16'h1000})
        $display("FAIL rr_grant%0d: gnt=%b rd=%b wr=%b addr=%h, want 01 1 0 1000",
                 g, gnt, rd_mem, wr_mem, addr_mem);
      else if (owner == 1 && {gnt, rd_mem, wr_mem, addr_mem, wdata_mem} !==
               {2'b10, 1'b0, 1'b1, 16'h2000, 8'hC3})
        $display("FAIL rr_grant%0d: gnt=%b rd=%b wr=%b addr=%h wdata=%h, want 10 0 1 2000 c3",
                 g, gnt, rd_mem, wr_mem, addr_mem, wdata_mem);
      else n_pass++;
      for (int b = 0; b < BURST_LEN; b++) begin
        ready_mem = 1'b1; rdata_mem = 8'($urandom);
        tick();
      end
      ready_mem = 1'b0;
      n_checks++;
      if ({gnt, busy} !== 3'b001)
        $display("FAIL rr_done%0d: gnt=%b busy=%b, want 00 1", g, gnt, busy);
      else n_pass++;
      tick();
      n_checks++;
      if ({gnt, busy} !== 3'b000)
        $display("FAIL rr_gap%0d: gnt=%b busy=%b, want 00 0", g, gnt, busy);
      else n_pass++;
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_hold_during_burst();
    do_reset();
    rd_mem_0 = 1'b1; addr_mem_0 = 16'h0300;
    tick();
    for (int b = 0; b < BURST_LEN; b++) begin
      if (b == 2) begin
        wr_mem_1 = 1'b1; addr_mem_1 = 16'h0400;
      end
      ready_mem = 1'b1;
      #1;
      n_checks++;
      if ({gnt, ready_mem_0, ready_mem_1} !== {2'b01, 1'b1, 1'b0})
        $display("FAIL hold_beat%0d: gnt=%b rdy0=%b rdy1=%b, want 01 1 0", b, gnt, ready_mem_0, ready_mem_1);
      else n_pass++;
      tick();
    end
    ready_mem = 1'b0; rd_mem_0 = 1'b0;
    n_checks++;
    if (gnt !== 2'b00) $display("FAIL hold_gap1: gnt=%b, want 00", gnt);
    else n_pass++;
    tick();
    n_checks++;
    if (gnt !== 2'b00) $display("FAIL hold_gap2: gnt=%b, want 00", gnt);
    else n_pass++;
    tick();
    n_checks++;
    if ({gnt, wr_mem, addr_mem} !== {2'b10, 1'b1, 16'h0400})
      $display("FAIL hold_regrant: gnt=%b wr=%b addr=%h, want 10 1 0400", gnt, wr_mem, addr_mem);
    else n_pass++;
    clear_inputs();
  endtask

  task automatic test_abort();
    do_reset();
    rd_mem_1 = 1'b1; wr_mem_1 = 1'b1; addr_mem_1 = 16'h5550; wdata_1 = 8'hA5;
    tick();
    n_checks++;
    if ({gnt, rd_mem, wr_mem, wdata_mem} !== {2'b10, 1'b0, 1'b1, 8'hA5})
      $display("FAIL abort_grant: gnt=%b rd=%b wr=%b wdata=%h, want 10 0 1 a5", gnt, rd_mem, wr_mem, wdata_mem);
    else n_pass++;
    for (int b = 0; b < 2; b++) begin
      ready_mem = 1'b1;
      tick();
    end
    ready_mem = 1'b0; rd_mem_1 = 1'b0; wr_mem_1 = 1'b0;
    tick();
    ready_mem = 1'b1;
    #1;
    n_checks++;
    if ({gnt, busy, ready_mem_1, ready_mem_0, wr_mem} !== {2'b00, 1'b1, 1'b0, 1'b0, 1'b0})
      $display("FAIL abort_done: gnt=%b busy=%b rdy1=%b rdy0=%b wr=%b, want 00 1 0 0 0",
               gnt, busy, ready_mem_1, ready_mem_0, wr_mem);
    else n_pass++;
    tick();
    n_checks++;
    if ({gnt, busy, ready_mem_1} !== 4'b0000)
      $display("FAIL abort_idle: gnt=%b busy=%b rdy1=%b, want 00 0 0", gnt, busy, ready_mem_1);
    else n_pass++;
    clear_inputs();
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    rd_mem_0 = 1'b1; addr_mem_0 = 16'h40B4;
    tick();
    for (int b = 0; b < 2; b++) begin
      ready_mem = 1'b1;
      tick();
    end
    reset = 1'b1;
    tick();
    n_checks++;
    if ({gnt, rd_mem, busy, ready_mem_0} !== 5'b0)
      $display("FAIL midreset: gnt=%b rd=%b busy=%b rdy0=%b, want 00 0 0 0", gnt, rd_mem, busy, ready_mem_0);
    else n_pass++;
    reset = 1'b0; ready_mem = 1'b0;
    tick();
    n_checks++;
    if ({gnt, rd_mem, addr_mem} !== {2'b01, 1'b1, 16'h40B4})
      $display("FAIL midreset_regrant: gnt=%b rd=%b addr=%h, want 01 1 40b4", gnt, rd_mem, addr_mem);
    else n_pass++;
    clear_inputs();
  endtask

  task automatic test_timeout();
    int first_err, n_err;
    do_reset();
    rd_mem_0 = 1'b1; wr_mem_1 = 1'b1;
    tick();
    first_err = -1; n_err = 0;
`ifdef CACHE_ARB_TIMEOUT_EN
    for (int k = 1; k <= TIMEOUT + 2; k++) begin
      tick();
      if (err_timeout === 1'b1) begin
        n_err++;
        if (first_err < 0) first_err = k;
      end
      if (k == TIMEOUT) begin
        n_checks++;
        if ({gnt, busy} !== 3'b001) $display("FAIL wd_revoke: gnt=%b busy=%b, want 00 1", gnt, busy);
        else n_pass++;
      end
    end
    n_checks++;
    if (first_err != TIMEOUT || n_err != 1)
      $display("FAIL wd_pulse: first at %0d count %0d, want at %0d count 1", first_err, n_err, TIMEOUT);
    else n_pass++;
    n_checks++;
    if (gnt !== 2'b10) $display("FAIL wd_next_grant: gnt=%b, want 10", gnt);
    else n_pass++;
`else
    for (int k = 1; k <= TIMEOUT + 4; k++) begin
      tick();
      if (err_timeout !== 1'b0) n_err++;
    end
    n_checks++;
    if (gnt !== 2'b01 || n_err != 0)
      $display("FAIL no_wd_wait: gnt=%b err cycles=%0d, want 01 and 0", gnt, n_err);
    else n_pass++;
`endif
    clear_inputs();
  endtask

  // Randomized run: each requester issues line transfers, holds them until BURST_LEN beats
  // arrive (or it gives up early), and the model tracks only who owns the port.
  typedef struct {
    bit          active;
    bit          is_wr;
    bit          both;
    logic [15:0] addr;
    logic [7:0]  wdata;
    int          got;
    int          abort_at;
  } rq_t;

  task automatic test_random();
    rq_t         rq [2];
    int          m_owner, prev_owner, m_beats;
    bit          m_done, m_last;
    logic [1:0]  e_gnt;
    logic        e_rd, e_wr, e_r0, e_r1, req0, req1;
    logic [15:0] e_addr;
    logic [7:0]  e_wd, e_d0, e_d1;
    do_reset();
    m_owner = -1; m_done = 1'b0; m_last = 1'b1; m_beats = 0;
    for (int r = 0; r < 2; r++) begin
      rq[r].active = 1'b0; rq[r].got = 0;
    end
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int r = 0; r < 2; r++) begin
        if (!rq[r].active && $urandom_range(0, 3) == 0) begin
          rq[r].active   = 1'b1;
          rq[r].is_wr    = 1'($urandom);
          rq[r].both     = rq[r].is_wr && ($urandom_range(0, 1) == 1);
          rq[r].addr     = 16'($urandom);
          rq[r].wdata    = 8'($urandom);
          rq[r].got      = 0;
          rq[r].abort_at = ($urandom_range(0, 3) == 0) ? $urandom_range(1, BURST_LEN - 1) : BURST_LEN;
        end
      end
      rd_mem_0 = rq[0].active && (!rq[0].is_wr || rq[0].both);
      wr_mem_0 = rq[0].active && rq[0].is_wr;
      addr_mem_0 = rq[0].addr; wdata_0 = rq[0].wdata;
      rd_mem_1 = rq[1].active && (!rq[1].is_wr || rq[1].both);
      wr_mem_1 = rq[1].active && rq[1].is_wr;
      addr_mem_1 = rq[1].addr; wdata_1 = rq[1].wdata;
      ready_mem = ($urandom_range(0, 2) != 0);
      rdata_mem = 8'($urandom);
      reset = ($urandom_range(0, 299) == 0);
      #1;
      e_gnt = 2'b00; e_rd = 1'b0; e_wr = 1'b0; e_addr = '0; e_wd = '0;
      if (m_owner == 0) begin
        e_gnt = 2'b01; e_wr = wr_mem_0; e_rd = rd_mem_0 && !wr_mem_0; e_addr = addr_mem_0; e_wd = wdata_0;
      end else if (m_owner == 1) begin
        e_gnt = 2'b10; e_wr = wr_mem_1; e_rd = rd_mem_1 && !wr_mem_1; e_addr = addr_mem_1; e_wd = wdata_1;
      end
      e_r0 = (m_owner == 0) && ready_mem;
      e_r1 = (m_owner == 1) && ready_mem;
      e_d0 = (m_owner == 0) ? rdata_mem : 8'h00;
      e_d1 = (m_owner == 1) ? rdata_mem : 8'h00;
      n_checks++;
      if ({gnt, busy, err_timeout} !== {e_gnt, (m_owner >= 0) || m_done, 1'b0})
        $display("FAIL rand_ctrl@%0d: gnt=%b busy=%b err=%b, want %b %b 0",
                 cyc, gnt, busy, err_timeout, e_gnt, (m_owner >= 0) || m_done);
      else n_pass++;
      n_checks++;
      if ({rd_mem, wr_mem, addr_mem, wdata_mem} !== {e_rd, e_wr, e_addr, e_wd})
        $display("FAIL rand_mem@%0d: rd=%b wr=%b addr=%h wdata=%h, want %b %b %h %h",
                 cyc, rd_mem, wr_mem, addr_mem, wdata_mem, e_rd, e_wr, e_addr, e_wd);
      else n_pass++;
      n_checks++;
      if ({ready_mem_0, ready_mem_1, rdata_0, rdata_1} !== {e_r0, e_r1, e_d0, e_d1})
        $display("FAIL rand_ret@%0d: rdy0=%b rdy1=%b rdata0=%h rdata1=%h, want %b %b %h %h",
                 cyc, ready_mem_0, ready_mem_1, rdata_0, rdata_1, e_r0, e_r1, e_d0, e_d1);
      else n_pass++;
      @(posedge clock);
      req0 = rd_mem_0 | wr_mem_0;
      req1 = rd_mem_1 | wr_mem_1;
      prev_owner = m_owner;
      if (reset) begin
        m_owner = -1; m_done = 1'b0; m_last = 1'b1; m_beats = 0;
      end else if (m_owner >= 0) begin
        if (ready_mem) m_beats++;
        if (m_beats >= BURST_LEN || !(m_owner == 0 ? req0 : req1)) begin
          m_owner = -1; m_done = 1'b1;
        end
      end else if (m_done) begin
        m_done = 1'b0;
      end else if (req0 || req1) begin
        m_owner = (req0 && req1) ? (m_last ? 0 : 1) : (req1 ? 1 : 0);
        m_last  = (m_owner == 1);
        m_beats = 0;
      end
      for (int r = 0; r < 2; r++) begin
        if (reset) rq[r].got = 0;
        else if (prev_owner == r && ready_mem) rq[r].got++;
        if (rq[r].active && rq[r].got >= BURST_LEN) rq[r].active = 1'b0;
        else if (rq[r].active && prev_owner == r && rq[r].got >= rq[r].abort_at) rq[r].active = 1'b0;
      end
      #1;
    end
    reset = 1'b0;
    clear_inputs();
  endtask

  initial begin
    reset = 1'b0;
    clear_inputs();
    test_reset();
    test_single_read();
    test_round_robin();
    test_hold_during_burst();
    test_abort();
    test_reset_mid_burst();
    test_timeout();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
